i2c_target_responder: RTL and testbench

I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_target_responder_if.sv | 18 +
 rtl/i2c_bus_sync.sv | 83 ++++++++
 rtl/i2c_target_responder.sv | 169 ++++++++++++++++
 tb/tb_i2c_target_responder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state codes (also reported on
// o_status[7:2]), ACK/NACK bit levels and the bus event bundle.
package i2c_pkg;

  typedef enum logic [5:0] {
    S_IDLE     = 6'd0,
    S_DEV_ADDR = 6'd1,
    S_ACK_DEV  = 6'd2,
    S_REG_ADDR = 6'd3,
    S_ACK_REG  = 6'd4,
    S_WR_DATA  = 6'd5,
    S_ACK_WR   = 6'd6,
    S_RD_LOAD  = 6'd7,
    S_RD_DATA  = 6'd8,
    S_HOST_ACK = 6'd9
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // One-cycle bus events plus the conditioned SDA level.
  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda;
  } i2c_bus_ev_t;

endpackage

// File: rtl/i2c_target_responder_if.sv
// Bus and register-port bundle for the I2C target; the host/bench side
// takes master, the target side takes slave.
interface i2c_target_responder_if;
  logic       scl;
  logic       sda;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic [7:0] status;

  modport master (output scl, sda, reg_rdata,
                  input  sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, status);
  modport slave  (input  scl, sda, reg_rdata,
                  output sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, status);
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA conditioning: 2-FF synchronizers, optional glitch filter
// (I2C_TARGET_GLITCH_FILTER_EN), edge detect and START/STOP detect.
// Events are held off after reset until the pipeline holds real bus samples.
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_scl,
  input  logic        i_sda,
  output i2c_bus_ev_t o_ev
);

  logic [1:0] s1_q, s2_q, flt, prev_q;   // bit 1 = SCL, bit 0 = SDA

  // Two-stage synchronizer; idle bus level is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
    end else begin
      s1_q <= {i_scl, i_sda};
      s2_q <= s1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int STAGES = 3 + FILT_LEN;
  localparam int CW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  for (genvar g = 0; g < 2; g++) begin : g_flt
    logic [CW-1:0] cnt_q;
    logic          out_q;
    // Take a new level only after FILT_LEN consecutive differing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q <= '0;
        out_q <= 1'b1;
      end else if (s2_q[g] == out_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        cnt_q <= '0;
        out_q <= s2_q[g];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign flt[g] = out_q;
  end
`else
  // Without the filter FILT_LEN has no effect on the pipeline depth.
  localparam int STAGES = 3 + (FILT_LEN * 0);
  assign flt = s2_q;
`endif

  logic [STAGES:0] vld_pipe;

  // Previous conditioned levels plus the post-reset arming pipe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q   <= 2'b11;
      vld_pipe <= '0;
    end else begin
      prev_q   <= flt;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  // Edge and START/STOP decode from current vs previous levels.
  always_comb begin
    o_ev     = '0;
    o_ev.sda = flt[0];
    if (vld_pipe[STAGES]) begin
      o_ev.scl_rise = flt[1] & ~prev_q[1];
      o_ev.scl_fall = ~flt[1] & prev_q[1];
      o_ev.start    = flt[1] & prev_q[1] & prev_q[0] & ~flt[0];
      o_ev.stop     = flt[1] & prev_q[1] & ~prev_q[0] & flt[0];
    end
  end

endmodule

// File: rtl/i2c_target_responder.sv
// I2C register target: 7-bit address DEV_ADDR, register pointer with
// auto-increment, burst write and burst read. Optional SCL/SDA glitch
// filter enabled with I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h2D,
  parameter int         FILT_LEN = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  output logic       o_reg_rd,
  input  logic [7:0] i_reg_rdata,
  output logic [7:0] o_status
);

  i2c_bus_ev_t ev;

  i2c_bus_sync #(.FILT_LEN(FILT_LEN)) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_scl  (i_scl),
    .i_sda  (i_sda),
    .o_ev   (ev)
  );

  i2c_state_e state_q;
  logic [7:0] shreg_q, ptr_q, wdata_q;
  logic [3:0] cnt_q;    // bit counter; load phase while in S_RD_LOAD
  logic       oe_q, we_q, rd_q, rw_q, busy_q, hit_q;
  logic [7:0] rx_byte;
  logic       last_bit;

  assign rx_byte  = {shreg_q[6:0], ev.sda};
  assign last_bit = (cnt_q == 4'd7);

  // Protocol FSM; STOP outranks START, both outrank per-state handling.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      ptr_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      rd_q <= 1'b0;
      if (ev.stop) begin
        state_q <= S_IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
        hit_q   <= 1'b0;
      end else if (ev.start) begin
        state_q <= S_DEV_ADDR;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: if (ev.scl_rise) begin
            shreg_q <= rx_byte;
            cnt_q   <= cnt_q + 4'd1;
            if (last_bit) begin
              if (state_q == S_DEV_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_q <= S_ACK_DEV;
                  rw_q    <= rx_byte[0];
                  hit_q   <= 1'b1;
                end else begin
                  state_q <= S_IDLE;
                end
              end else if (state_q == S_REG_ADDR) begin
                ptr_q   <= rx_byte;
                state_q <= S_ACK_REG;
              end else begin
                wdata_q <= rx_byte;
                we_q    <= 1'b1;
                state_q <= S_ACK_WR;
              end
            end
          end
          // Read: prefetch during the ACK high phase so bit 7 goes out at the fall.
          S_ACK_DEV: begin
            if (ev.scl_fall) begin
              if (!oe_q) begin
                oe_q <= ~I2C_ACK;
              end else begin
                oe_q    <= 1'b0;
                cnt_q   <= '0;
                state_q <= S_REG_ADDR;
              end
            end else if (ev.scl_rise && oe_q && rw_q) begin
              state_q <= S_RD_LOAD;
              rd_q    <= 1'b1;
              cnt_q   <= '0;
            end
          end
          S_ACK_REG, S_ACK_WR: if (ev.scl_fall) begin
            if (!oe_q) begin
              oe_q <= ~I2C_ACK;
              if (state_q == S_ACK_WR) ptr_q <= ptr_q + 8'd1;
            end else begin
              oe_q    <= 1'b0;
              cnt_q   <= '0;
              state_q <= S_WR_DATA;
            end
          end
          // Phase 0: strobe cycle, phase 1: latch data, phase 2: wait for fall.
          S_RD_LOAD: begin
            if (cnt_q == 4'd0) begin
              cnt_q <= 4'd1;
            end else if (cnt_q == 4'd1) begin
              shreg_q <= i_reg_rdata;
              ptr_q   <= ptr_q + 8'd1;
              cnt_q   <= 4'd2;
            end else if (ev.scl_fall) begin
              oe_q    <= ~shreg_q[7];
              shreg_q <= {shreg_q[6:0], 1'b0};
              cnt_q   <= 4'd1;
              state_q <= S_RD_DATA;
            end
          end
          S_RD_DATA: if (ev.scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_q    <= 1'b0;
              state_q <= S_HOST_ACK;
            end else begin
              oe_q    <= ~shreg_q[7];
              shreg_q <= {shreg_q[6:0], 1'b0};
              cnt_q   <= cnt_q + 4'd1;
            end
          end
          S_HOST_ACK: if (ev.scl_rise) begin
            if (ev.sda == I2C_NACK) begin
              state_q <= S_IDLE;
              hit_q   <= 1'b0;
            end else begin
              state_q <= S_RD_LOAD;
              rd_q    <= 1'b1;
              cnt_q   <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_sda_oe    = oe_q;
  assign o_reg_addr  = ptr_q;
  assign o_reg_wdata = wdata_q;
  assign o_reg_we    = we_q;
  assign o_reg_rd    = rd_q;
  assign o_status    = {state_q, hit_q, busy_q};

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: bit-banged host, open-drain SDA,
// register model answering reads with addr ^ 8'hA5.
module tb_i2c_target_responder;

  localparam int Q = 8;   // i_clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_sda = 1'b1;
  logic oe_watch = 1'b0;
  logic oe_seen = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rd = 0;
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];

  always #5 clk = ~clk;

  i2c_target_responder_if bus();
  assign bus.sda = host_sda & ~bus.sda_oe;

  i2c_target_responder #(.DEV_ADDR(7'h2D), .FILT_LEN(3)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_scl      (bus.scl),
    .i_sda      (bus.sda),
    .o_sda_oe   (bus.sda_oe),
    .o_reg_addr (bus.reg_addr),
    .o_reg_wdata(bus.reg_wdata),
    .o_reg_we   (bus.reg_we),
    .o_reg_rd   (bus.reg_rd),
    .i_reg_rdata(bus.reg_rdata),
    .o_status   (bus.status)
  );

  // register file model: data valid the cycle after the read strobe
  always @(posedge clk or negedge rst_n)
    if (!rst_n) bus.reg_rdata <= '0;
    else if (bus.reg_rd) bus.reg_rdata <= bus.reg_addr ^ 8'hA5;

  // strobe logging
  always @(negedge clk) begin
    if (bus.reg_we) begin
      wa_q.push_back(bus.reg_addr);
      wd_q.push_back(bus.reg_wdata);
    end
    if (bus.reg_rd) n_rd++;
    if (oe_watch && bus.sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] wa(input int i);
    return (i < wa_q.size()) ? wa_q[i] : 8'hxx;
  endfunction
  function automatic logic [7:0] wd(input int i);
    return (i < wd_q.size()) ? wd_q[i] : 8'hxx;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    host_sda = 1'b1; wait_clk(Q);
    bus.scl  = 1'b1; wait_clk(Q);
    host_sda = 1'b0; wait_clk(Q);
    bus.scl  = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    host_sda = 1'b0; wait_clk(Q);
    bus.scl  = 1'b1; wait_clk(Q);
    host_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic clk_bit(input logic b, output logic smp);
    host_sda = b;   wait_clk(Q);
    bus.scl  = 1'b1; wait_clk(Q);
    smp = bus.sda;  wait_clk(Q);
    bus.scl  = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic host_nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(host_nack, s);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] d;
    int         rd0;
    logic [7:0] rd_exp [11] = '{8'h89, 8'h88, 8'h8B, 8'h8A, 8'h95, 8'h94,
                                8'h97, 8'h96, 8'h91, 8'h90, 8'h93};

    bus.scl = 1'b1;
    wait_clk(3);
    chk("rst_oe", bus.sda_oe, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_addr", bus.reg_addr, 0);
    chk("rst_we_rd_wdata", {bus.reg_we, bus.reg_rd, bus.reg_wdata}, 0);
    rst_n = 1'b1;
    wait_clk(10);

    // single write 0x82 -> reg 0x2C
    i2c_start();
    send_byte(8'h5A, ack); chk("w_dev_ack", ack, 0);
    chk("w_status", bus.status, 8'h0F);
    send_byte(8'h2C, ack); chk("w_reg_ack", ack, 0);
    send_byte(8'h82, ack); chk("w_data_ack", ack, 0);
    i2c_stop(); wait_clk(4);
    chk("w_count", wa_q.size(), 1);
    chk("w_addr", wa(0), 8'h2C);
    chk("w_data", wd(0), 8'h82);
    chk("w_idle", bus.status, 0);

    // pointer write, repeated START, 11-byte read
    wa_q.delete(); wd_q.delete();
    i2c_start();
    send_byte(8'h5A, ack); chk("r_wdev_ack", ack, 0);
    send_byte(8'h2C, ack); chk("r_reg_ack", ack, 0);
    i2c_start();
    rd0 = n_rd;
    send_byte(8'h5B, ack); chk("r_dev_ack", ack, 0);
    for (int i = 0; i < 11; i++) begin
      recv_byte(i == 10, d);
      chk($sformatf("r_byte%0d", i), d, rd_exp[i]);
    end
    chk("r_rd_pulses", n_rd - rd0, 11);
    chk("r_end_status", bus.status, 8'h01);
    chk("r_no_we", wa_q.size(), 0);
    i2c_stop(); wait_clk(4);

    // wrong address
    rd0 = n_rd;
    i2c_start();
    send_byte(8'h5C, ack); chk("n_nack", ack, 1);
    chk("n_status", bus.status, 8'h01);
    i2c_stop(); wait_clk(4);
    chk("n_no_we", wa_q.size(), 0);
    chk("n_no_rd", n_rd - rd0, 0);

    // burst write across pointer wrap
    i2c_start();
    send_byte(8'h5A, ack); chk("wrap_dev_ack", ack, 0);
    send_byte(8'hFE, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    send_byte(8'h33, ack); chk("wrap_last_ack", ack, 0);
    i2c_stop(); wait_clk(4);
    chk("wrap_count", wa_q.size(), 3);
    chk("wrap_a0", wa(0), 8'hFE); chk("wrap_d0", wd(0), 8'h11);
    chk("wrap_a1", wa(1), 8'hFF); chk("wrap_d1", wd(1), 8'h22);
    chk("wrap_a2", wa(2), 8'h00); chk("wrap_d2", wd(2), 8'h33);

    // STOP after 4 data bits
    wa_q.delete(); wd_q.delete();
    i2c_start();
    send_byte(8'h5A, ack);
    send_byte(8'h10, ack);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
    i2c_stop(); wait_clk(4);
    chk("part_no_we", wa_q.size(), 0);
    chk("part_idle", bus.status, 0);

    // reset while driving read data (0x10 ^ A5 = B5: bit7 1, bit6 0)
    i2c_start();
    send_byte(8'h5B, ack); chk("rr_dev_ack", ack, 0);
    clk_bit(1'b1, s); chk("rr_bit7", s, 1);
    chk("rr_drive", bus.sda_oe, 1);
    chk("rr_state", bus.status, 8'h23);
    #1 rst_n = 1'b0;
    #1 chk("rr_release", bus.sda_oe, 0);
    chk("rr_status", bus.status, 0);
    wait_clk(2);
    rst_n = 1'b1;
    oe_watch = 1'b1;
    for (int i = 0; i < 7; i++) clk_bit(1'b1, s);
    chk("rr_ignored_oe", oe_seen, 0);
    chk("rr_ignored_status", bus.status, 0);
    i2c_stop(); wait_clk(4);
    oe_watch = 1'b0;
    i2c_start();
    send_byte(8'h5A, ack); chk("rr_fresh_ack", ack, 0);
    i2c_stop(); wait_clk(4);

    // one-cycle SCL glitch after START
    i2c_start();
    @(negedge clk); bus.scl = 1'b1;
    @(negedge clk); bus.scl = 1'b0;
    wait_clk(Q);
    send_byte(8'h5A, ack);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    chk("glitch_ack", ack, 0);
    chk("glitch_hit", bus.status[1], 1);
`else
    chk("glitch_ack", ack, 1);
    chk("glitch_hit", bus.status[1], 0);
`endif
    i2c_stop(); wait_clk(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
